// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_pkg
// Description : Shared definitions for the LC-3 memory interface slice.
//               Holds the memory-interface FSM state encoding, the default
//               bus/address widths and the read-buffer fill used when an
//               access is abandoned by the watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_pkg;

    // Default widths of the main bus / MDR and of the MAR / memory address.
    localparam int c_DEF_DW = 16;
    localparam int c_DEF_AW = 16;

    // Memory-interface FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_REQ  = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;
    localparam state_t c_ST_ERR  = 2'd3;

    // Bit replicated across the read buffer on a watchdog abort (all ones).
    localparam logic c_FILL_BIT = 1'b1;

endpackage : lc3_pkg
`default_nettype wire

// File: rtl/lc3_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_array
// Description : Behavioural variable-latency memory with the req/ack port of
//               lc3_mem_if. An access is acknowledged in the (LATENCY+1)-th
//               cycle that mem_req is held high; ack and read data are
//               combinational so LATENCY=0 acks in the first request cycle.
//               Only the low DEPTH_BITS address bits select a word.
// Ports       : clk, rst              - clock, async active-high reset
//               mem_req/mem_we        - request valid / write qualifier
//               mem_addr/mem_wdata    - request address / write data
//               mem_rdata/mem_ack     - read data / completion
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_array #(
    parameter int DW         = 16,
    parameter int AW         = 16,
    parameter int LATENCY    = 0,
    parameter int DEPTH_BITS = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_ack
);

    logic [DW-1:0]         r_mem [2**DEPTH_BITS];
    logic [7:0]            r_cnt;
    logic [DEPTH_BITS-1:0] w_idx;
    logic                  w_unused_addr;

    assign w_idx         = mem_addr[DEPTH_BITS-1:0];
    assign w_unused_addr = ^mem_addr[AW-1:DEPTH_BITS];
    assign mem_ack       = mem_req && (r_cnt == 8'(LATENCY));
    assign mem_rdata     = r_mem[w_idx];

    // Wait-cycle counter: advances while a request waits, clears otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (mem_req && !mem_ack) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_req && mem_ack && mem_we) begin
            r_mem[w_idx] <= mem_wdata;
        end
    end

endmodule : lc3_mem_array
`default_nettype wire

// File: rtl/lc3_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_if
// Description : LC-3 MAR/MDR memory interface. Issues a registered req/ack
//               access to an external variable-latency memory and reports
//               completion to the microsequencer on R.
//               Optional macro LC3_MEMIF_TIMEOUT_EN adds a watchdog that
//               abandons a request after TIMEOUT cycles (sticky err, R=1,
//               read buffer filled with all ones).
// Ports       : clk, rst             - clock, async active-high reset
//               LD_MAR, LD_MDR       - register loads from main_bus / RDB
//               GateMDR              - drive MDR onto main_bus
//               MIO_EN, RW           - access enable, 1=write 0=read
//               main_bus             - shared tri-state bus
//               R, err               - ready, sticky timeout flag
//               mem_req .. mem_ack   - external memory handshake
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_if
    import lc3_pkg::*;
#(
    parameter int DW      = c_DEF_DW,
    parameter int AW      = c_DEF_AW,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LD_MAR,
    input  logic          LD_MDR,
    input  logic          GateMDR,
    input  logic          MIO_EN,
    input  logic          RW,
    inout  wire  [DW-1:0] main_bus,
    output logic          R,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    state_t        r_state;
    logic [AW-1:0] r_mar;
    logic [DW-1:0] r_mdr;
    logic [DW-1:0] r_rdb;
    logic          r_r;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [AW-1:0] w_mar_in;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("lc3_mem_if: TIMEOUT must be at least 2");
    end

    // MAR takes the low AW bits of the bus, zero-extended when wider.
    if (AW > DW) begin : g_mar_zext
        assign w_mar_in = {{(AW-DW){1'b0}}, main_bus};
    end else begin : g_mar_trunc
        assign w_mar_in = main_bus[AW-1:0];
    end

    // Only the MDR register ever reaches the bus, never raw memory data.
    assign main_bus  = GateMDR ? r_mdr : {DW{1'bz}};

    assign R         = r_r;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

`ifdef LC3_MEMIF_TIMEOUT_EN
    localparam int c_CW = $clog2(TIMEOUT);
    logic [c_CW-1:0] r_cnt;
    logic            r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_mar       <= '0;
            r_mdr       <= '0;
            r_rdb       <= '0;
            r_r         <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef LC3_MEMIF_TIMEOUT_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            // Register loads are independent of the FSM; an in-flight
            // request keeps its own frozen copy of address/data.
            if (LD_MAR) begin
                r_mar <= w_mar_in;
            end
            if (LD_MDR) begin
                r_mdr <= MIO_EN ? r_rdb : main_bus;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (MIO_EN) begin
                        r_mem_addr  <= r_mar;
                        r_mem_wdata <= r_mdr;
                        r_mem_we    <= RW;
                        r_mem_req   <= 1'b1;
                        r_state     <= c_ST_REQ;
`ifdef LC3_MEMIF_TIMEOUT_EN
                        r_cnt       <= '0;
`endif
                    end
                end

                // MIO_EN is deliberately not consulted here: a started
                // access always runs to completion.
                c_ST_REQ: begin
                    if (mem_ack) begin
                        if (!r_mem_we) begin
                            r_rdb <= mem_rdata;
                        end
                        r_mem_req <= 1'b0;
                        r_r       <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end
`ifdef LC3_MEMIF_TIMEOUT_EN
                    else if (r_cnt == c_CW'(TIMEOUT - 1)) begin
                        r_rdb     <= {DW{c_FILL_BIT}};
                        r_mem_req <= 1'b0;
                        r_r       <= 1'b1;
                        r_err     <= 1'b1;
                        r_state   <= c_ST_ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end

                // ERR exits exactly like DONE; err itself stays sticky.
                c_ST_DONE, c_ST_ERR: begin
                    if (!MIO_EN) begin
                        r_r     <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule : lc3_mem_if
`default_nettype wire
